// File: rtl/aes_pkg.sv
// Shared types for the AES control-apply slice: control register layout and FSM encoding.
package aes_pkg;

    typedef struct packed {
        logic [23:0] reserved;
        logic [2:0]  key_len;
        logic [1:0]  mode;
        logic [1:0]  operation;
        logic [0:0]  manual_operation;
    } ctrl_reg_t;

    // Sparse encoding: any single-bit upset lands on an illegal code that decodes to ERROR.
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        READY = 3'b011,
        RUN   = 3'b101,
        ERROR = 3'b110
    } aes_ctrl_apply_e;

    localparam int unsigned MANUAL_BIT = 0;

endpackage

// File: rtl/aes_ctrl_pending_buf.sv
// Single-entry holding buffer for control updates arriving mid-operation, with a
// saturating count of entries discarded before they could be applied.
module aes_ctrl_pending_buf
    import aes_pkg::*;
#(
    parameter int unsigned DropCntW = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_i,
    input  logic                clr_i,
    input  logic                kill_i,
    input  ctrl_reg_t           data_i,
    output logic                valid_o,
    output ctrl_reg_t           data_o,
    output logic [DropCntW-1:0] drop_cnt_o
);

    logic                valid_q, valid_d;
    ctrl_reg_t           data_q, data_d;
    logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;
    logic                drop_evt;

    // A held entry is lost when it is overwritten or superseded without being applied.
    assign drop_evt = valid_q && (wr_i || kill_i);

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_i || kill_i) begin
            valid_d = 1'b0;
        end else if (wr_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
        if (drop_evt && (drop_cnt_q != {DropCntW{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: rtl/aes_ctrl_apply.sv
// Applies committed AES control values to the datapath, buffering updates during an operation.
// Optional RUN-state watchdog enabled by defining AES_CTRL_WATCHDOG_EN.
module aes_ctrl_apply
    import aes_pkg::*;
#(
    parameter ctrl_reg_t   CtrlReset     = '0,
    parameter int unsigned DropCntW      = 8,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  ctrl_reg_t           ctrl_q_i,
    input  logic                ctrl_qe_i,
    input  logic                err_update_i,
    input  logic                err_storage_i,
    input  logic                start_req_i,
    input  logic                data_ready_i,
    input  logic                core_done_i,
    output ctrl_reg_t           ctrl_o,
    output logic                start_o,
    output logic                busy_o,
    output logic                pending_o,
    output logic [DropCntW-1:0] drop_cnt_o,
    output logic                alert_recov_o,
    output logic                alert_fatal_o
);

    if (TimeoutCycles == 0) begin : gen_bad_timeout
        $error("TimeoutCycles must be nonzero");
    end

    aes_ctrl_apply_e state_q, state_d;
    ctrl_reg_t       ctrl_q, ctrl_d;
    logic            start_q, start_d;
    logic            recov_q, recov_d;
    logic            fatal_q, fatal_d;

    logic            commit;
    logic            start_cond;
    logic            buf_wr, buf_clr, buf_kill;
    logic            buf_valid;
    ctrl_reg_t       buf_data;
    logic            wdog_expire;

    // An update flagged as mismatching by the shadow register must never be applied.
    assign commit     = ctrl_qe_i && !err_update_i;
    assign start_cond = ctrl_q[MANUAL_BIT] ? start_req_i : data_ready_i;

`ifdef AES_CTRL_WATCHDOG_EN
    localparam int unsigned WdogW = $clog2(TimeoutCycles + 1);

    logic [WdogW-1:0] wdog_q, wdog_d;

    // wdog_q holds completed RUN cycles, so the limit is hit during RUN cycle TimeoutCycles.
    assign wdog_expire = (state_q == RUN) && (wdog_q == WdogW'(TimeoutCycles - 1));
    assign wdog_d      = (state_q == RUN) ? wdog_q + 1'b1 : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        start_d  = 1'b0;
        recov_d  = 1'b0;
        fatal_d  = fatal_q;
        buf_wr   = 1'b0;
        buf_clr  = 1'b0;
        buf_kill = 1'b0;

        if (err_update_i && (state_q != ERROR)) begin
            recov_d = 1'b1;
        end

        if (err_storage_i) begin
            state_d = ERROR;
            fatal_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (commit) begin
                        ctrl_d  = ctrl_q_i;
                        state_d = READY;
                    end
                end
                READY: begin
                    if (commit) begin
                        ctrl_d = ctrl_q_i;
                    end
                    if (start_cond) begin
                        start_d = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (core_done_i) begin
                        state_d = READY;
                        if (commit) begin
                            ctrl_d   = ctrl_q_i;
                            buf_kill = 1'b1;
                        end else if (buf_valid) begin
                            ctrl_d  = buf_data;
                            buf_clr = 1'b1;
                        end
                    end else if (wdog_expire) begin
                        state_d = ERROR;
                        fatal_d = 1'b1;
                    end else if (commit) begin
                        buf_wr = 1'b1;
                    end
                end
                ERROR: begin
                    fatal_d = 1'b1;
                end
                default: begin
                    state_d = ERROR;
                    fatal_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ctrl_q  <= CtrlReset;
            start_q <= 1'b0;
            recov_q <= 1'b0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            start_q <= start_d;
            recov_q <= recov_d;
            fatal_q <= fatal_d;
        end
    end

    aes_ctrl_pending_buf #(
        .DropCntW(DropCntW)
    ) u_pending_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_i      (buf_wr),
        .clr_i     (buf_clr),
        .kill_i    (buf_kill),
        .data_i    (ctrl_q_i),
        .valid_o   (buf_valid),
        .data_o    (buf_data),
        .drop_cnt_o(drop_cnt_o)
    );

    assign ctrl_o        = ctrl_q;
    assign start_o       = start_q;
    assign busy_o        = (state_q == RUN);
    assign pending_o     = buf_valid;
    assign alert_recov_o = recov_q;
    assign alert_fatal_o = fatal_q;

endmodule
